// File: rtl/pc_fetch.sv
// PC register and single-outstanding instruction fetch feeding the control unit.
// Each instruction is fetched over req/ack, issued until the stall input releases it, then the next PC is taken from branch.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  branch,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc_plus4 = pc_q + 32'd4;

  // Branch offsets are in words; all additions wrap modulo 2^32.
  always_comb begin
    next_pc = pc_plus4;
    case (branch)
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = pc_plus4 + (imm_ext << 2);
      2'b10:   next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      default: next_pc = {rs_data[31:2], 2'b00};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    addr_err_d  = addr_err_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          pc_d    = next_pc;
          state_d = FETCH;
          if (branch == 2'b11 && rs_data[1:0] != 2'b00) begin
            addr_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign func      = instr_q[5:0];
  assign addr_err  = addr_err_q;

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage that sits directly upstream of the control unit. It holds the PC and fetches one instruction at a time over a req/ack instruction-memory port. It presents the latched instruction's `op`/`func` fields to the control unit, then computes the next PC from the control unit's 2-bit `Branch` decision. It also provides `pc_plus4` for link-register writes (`PCtoReg`, jal).

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word-aligned.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `branch`  in  2  next-PC select from the control unit; already gated by ALU zero:
  - 00 = sequential
  - 01 = taken conditional branch
  - 10 = j/jal
  - 11 = jr
- `imm_ext`  in  32  extended 16-bit immediate of the current instruction (branch offset, in words).
- `rs_data`  in  32  register-file rs read value (jr target).
- `stall`  in  1  downstream hold; while high the current instruction stays issued.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ack`  in  1  memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  latched instruction.
- `instr_valid`  out  1  high while `instr` is issued to execute.
- `op`  out  6  `instr[31:26]`.
- `func`  out  6  `instr[5:0]`.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc + 4`, wraps modulo 2^32.
- `addr_err`  out  1  sticky flag: misaligned jr target seen.

## Operation
- **FSM states:** IDLE, FETCH, ISSUE.
- **IDLE:** entered on reset. Goes to FETCH unconditionally after one cycle. Any `imem_ack` arriving in IDLE is ignored.
- **FETCH:**
  - `imem_req`=1, decoded combinationally from state.
  - While `imem_ack`=0, stay in FETCH with the PC held.
  - On `imem_ack`=1: `instr` <= `imem_rdata`, go to ISSUE.
- **ISSUE:**
  - `instr_valid`=1 and `imem_req`=0.
  - If `stall`=1: hold `pc`, `instr`, and state.
  - If `stall`=0: sample `branch`, `imm_ext`, `rs_data`; load `pc` <= next_pc; go to FETCH.
- **next_pc arithmetic** (32-bit, all additions wrap modulo 2^32):
  - 00: `pc_plus4`
  - 01: `pc_plus4 + (imm_ext << 2)`
  - 10: `{pc_plus4[31:28], instr[25:0], 2'b00}`
  - 11: `{rs_data[31:2], 2'b00}`. If `rs_data[1:0]` != 0, also set `addr_err`=1, which holds until reset.
- `op`, `func`, and `pc_plus4` are combinational from the registered `instr` and `pc`.
- `branch` is ignored outside ISSUE.

## Timing
- **Reset values:**
  - `pc` = `RESET_PC`
  - state = IDLE
  - `instr` = 0, hence `op` = 0 and `func` = 0
  - `instr_valid` = 0, `imem_req` = 0, `addr_err` = 0
  - `imem_addr` = `RESET_PC`
- **Reset mid-operation:** asserting `rst_n` low in any state aborts immediately. No instruction is issued and any outstanding fetch is dropped.
- **First request:** `imem_req` rises in the 2nd cycle after `rst_n` deasserts.
- **Fetch latency:** ack in cycle N gives `instr_valid`=1 in cycle N+1.
- **Issue rate:** minimum 2 cycles per instruction (ack in the first FETCH cycle, ISSUE with `stall`=0).
- **PC update:** `pc` changes only on the ISSUE→FETCH edge. `imem_addr` shows the new PC in the first FETCH cycle.
- **No simultaneity conflict:** `imem_req` and `instr_valid` are mutually exclusive, so ack and stall never overlap.
- **Stall timing:** `stall` rising in the same cycle as ISSUE entry holds from that cycle. Release gives a PC update at the next edge.

## Test plan
- **Reset and sequential fetch:**
  - Stimulus: `RESET_PC`=0x0000_0000, memory acks immediately, `branch`=00.
  - Required: `imem_addr` sequence 0x0, 0x4, 0x8.
  - Required: `instr_valid` pulses every 2nd cycle.
  - Required: `op`/`func` match `imem_rdata` fields.
- **Conditional branch backward:**
  - Stimulus: pc=0x10, `branch`=01, `imm_ext`=0xFFFF_FFFE.
  - Required: next `imem_addr`=0x0C.
- **Jump and jr:**
  - Stimulus: j at pc=0x1000_0000 with `instr[25:0]`=0x40. Required: next PC 0x1000_0100.
  - Stimulus: jr with `rs_data`=0x203. Required: next PC 0x200 and `addr_err`=1, still 1 after ten further instructions.
- **Stall and slow memory:**
  - Stimulus: ack delayed 3 cycles. Required: `imem_req` held high with the address stable for all 3 cycles.
  - Stimulus: `stall` high for 4 ISSUE cycles. Required: `pc`/`instr` unchanged, then the PC advances on the edge after `stall` falls.
- **Wrap-around:**
  - Stimulus: pc=0xFFFF_FFFC, `branch`=00. Required: `pc_plus4`=0 and next `imem_addr`=0x0.
- **Async reset mid-fetch:**
  - Stimulus: `rst_n` low while in FETCH with ack pending.
  - Required: immediately `imem_req`=0, `instr_valid`=0, `pc`=`RESET_PC`.
  - Required: an ack arriving in IDLE does not change `instr`.
